// File: rtl/w5500_pkg.sv
// Shared constants for the W5500 frame responder: state encoding,
// operation-mode encodings and control-byte field positions.
package w5500_pkg;

    localparam int ADDR_BITS = 16;
    localparam int CTRL_BITS = 8;
    localparam int BSB_W     = 5;
    localparam int RWB_BIT   = 2;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_CTRL = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_SKIP = 3'd4;

    localparam logic [1:0] OM_VDM = 2'b00;
    localparam logic [1:0] OM_1B  = 2'b01;
    localparam logic [1:0] OM_2B  = 2'b10;
    localparam logic [1:0] OM_4B  = 2'b11;

    function automatic logic [2:0] om_len(input logic [1:0] om);
        case (om)
            OM_1B:   return 3'd1;
            OM_2B:   return 3'd2;
            OM_4B:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/w5500_spi_responder_sync.sv
// Two-flop synchronisers for SCLK, CS and MOSI with edge pulses
// derived from the synchronised SCLK and CS levels.
module spi_input_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sclk,
    input  logic i_cs,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_cs,
    output logic o_mosi
);

    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    // CS chain resets low so a CS already low at reset release
    // produces no falling edge and cannot start a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], i_sclk};
            cs_q   <= {cs_q[1:0], i_cs};
            mosi_q <= {mosi_q[0], i_mosi};
        end
    end

    assign o_sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign o_sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign o_cs_fall   = ~cs_q[1] & cs_q[2];
    assign o_cs_rise   = cs_q[1] & ~cs_q[2];
    assign o_cs        = cs_q[1];
    assign o_mosi      = mosi_q[1];

endmodule

// File: rtl/w5500_spi_responder.sv
// W5500-style SPI target: parses address/control/data frames and
// turns them into byte accesses on a local memory port.
module w5500_spi_responder
    import w5500_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_spi_clk,
    input  logic                 i_spi_cs,
    input  logic                 i_spi_mosi,
    output logic                 o_spi_miso,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [BSB_W-1:0]     o_mem_bsb,
    output logic [7:0]           o_mem_wdata,
    output logic                 o_mem_we,
    output logic                 o_mem_re,
    input  logic [7:0]           i_mem_rdata,
    output logic                 o_busy,
    output logic                 o_frame_done
);

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_s, mosi_s;

    spi_input_sync u_sync (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_sclk      (i_spi_clk),
        .i_cs        (i_spi_cs),
        .i_mosi      (i_spi_mosi),
        .o_sclk_rise (sclk_rise),
        .o_sclk_fall (sclk_fall),
        .o_cs_fall   (cs_fall),
        .o_cs_rise   (cs_rise),
        .o_cs        (cs_s),
        .o_mosi      (mosi_s)
    );

    state_t               state_q, state_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [BSB_W-1:0]     bsb_q, bsb_d;
    logic                 rwb_q, rwb_d;
    logic [1:0]           om_q, om_d;
    logic [7:0]           rx_q, rx_d;
    logic [7:0]           tx_q, tx_d;
    logic [2:0]           bytes_q, bytes_d;
    logic                 got_q, got_d;
    logic                 adv_q, adv_d;
    logic                 ld_q, ld_d;
    logic                 miso_q, miso_d;
    logic                 we_q, we_d;
    logic                 re_q, re_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [7:0]           byte_in;

    assign byte_in = {rx_q[6:0], mosi_s};

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        addr_d   = addr_q;
        bsb_d    = bsb_q;
        rwb_d    = rwb_q;
        om_d     = om_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        bytes_d  = bytes_q;
        got_d    = got_q;
        miso_d   = miso_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        adv_d    = 1'b0;
        we_d     = 1'b0;
        re_d     = 1'b0;
        done_d   = 1'b0;
        ld_d     = re_q;

        if (ld_q) begin
            tx_d = i_mem_rdata;
        end
        // Address advances the cycle after a byte so the write strobe
        // still sees the address the byte belongs to.
        if (adv_q) begin
            addr_d = addr_q + 16'd1;
            if (state_q == ST_DATA && !rwb_q) begin
                re_d = 1'b1;
            end
        end

        if (cs_s) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            if (cs_rise) begin
                busy_d = 1'b0;
                done_d = got_q;
                got_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        state_d  = ST_ADDR;
                        bitcnt_d = '0;
                        bytes_d  = '0;
                        got_d    = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_d   = {addr_q[ADDR_BITS-2:0], mosi_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'(ADDR_BITS - 1)) begin
                            state_d  = ST_CTRL;
                            bitcnt_d = '0;
                        end
                    end
                end
                ST_CTRL: begin
                    if (sclk_rise) begin
                        rx_d     = byte_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'(CTRL_BITS - 1)) begin
                            bsb_d    = byte_in[7:3];
                            rwb_d    = byte_in[RWB_BIT];
                            om_d     = byte_in[1:0];
                            state_d  = ST_DATA;
                            bitcnt_d = '0;
                            re_d     = ~byte_in[RWB_BIT];
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        rx_d     = byte_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            bitcnt_d = '0;
                            got_d    = 1'b1;
                            bytes_d  = bytes_q + 3'd1;
                            adv_d    = 1'b1;
                            if (rwb_q) begin
                                we_d    = 1'b1;
                                wdata_d = byte_in;
                            end
                            if (om_q != OM_VDM &&
                                bytes_q + 3'd1 == om_len(om_q)) begin
                                state_d = ST_SKIP;
                            end
                        end
                    end
                    if (sclk_fall && !rwb_q) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                ST_SKIP: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            addr_q   <= '0;
            bsb_q    <= '0;
            rwb_q    <= 1'b0;
            om_q     <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            bytes_q  <= '0;
            got_q    <= 1'b0;
            adv_q    <= 1'b0;
            ld_q     <= 1'b0;
            miso_q   <= 1'b0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            addr_q   <= addr_d;
            bsb_q    <= bsb_d;
            rwb_q    <= rwb_d;
            om_q     <= om_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            bytes_q  <= bytes_d;
            got_q    <= got_d;
            adv_q    <= adv_d;
            ld_q     <= ld_d;
            miso_q   <= miso_d;
            we_q     <= we_d;
            re_q     <= re_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_spi_miso   = miso_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_bsb    = bsb_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_we     = we_q;
    assign o_mem_re     = re_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_w5500_spi_responder.sv
// Scoreboard bench: a bit-banged SPI master drives frames while a
// monitor checks memory strobes against a frame-level reference model.
module tb_w5500_spi_responder;

    localparam int HALF = 120;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] mem_addr;
    logic [4:0]  mem_bsb;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [4:0]  b;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_re[$];
    logic [7:0]  ref_wr[int];
    logic [7:0]  wbuf[8];

    bit [7:0] dmem[65536];
    bit       dwr[65536];

    w5500_spi_responder dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_spi_clk    (sclk),
        .i_spi_cs     (cs),
        .i_spi_mosi   (mosi),
        .o_spi_miso   (miso),
        .o_mem_addr   (mem_addr),
        .o_mem_bsb    (mem_bsb),
        .o_mem_wdata  (mem_wdata),
        .o_mem_we     (mem_we),
        .o_mem_re     (mem_re),
        .i_mem_rdata  (mem_rdata),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed_byte(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo * 8'd13) ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
        return seed_byte(a);
    endfunction

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Local memory behind the DUT: read data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= dwr[mem_addr] ? dmem[mem_addr]
                                               : seed_byte(mem_addr);
        if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
            dwr[mem_addr]  <= 1'b1;
        end
    end

    always @(posedge clk) begin
        wr_t w;
        logic [15:0] ea;
        #1;
        if (frame_done === 1'b1) fd_cnt++;
        if (mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_we", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                w = exp_wr.pop_front();
                check("we_addr", 32'(mem_addr), 32'(w.a));
                check("we_bsb", 32'(mem_bsb), 32'(w.b));
                check("we_data", 32'(mem_wdata), 32'(w.d));
            end
        end
        if (mem_re === 1'b1) begin
            if (exp_re.size() == 0) begin
                check("unexpected_re", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                ea = exp_re.pop_front();
                check("re_addr", 32'(mem_addr), 32'(ea));
            end
        end
    end

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        #(HALF);
        r = miso;
        sclk = 1'b1;
        #(HALF);
        sclk = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] addr, input logic [7:0] ctrl,
                             input int nb, input int xbits);
        logic       rw;
        logic [1:0] om;
        int         len, eff, nre, lat;
        logic [7:0] expm[8];
        logic [7:0] got;
        logic [23:0] hdr;
        logic       r, acc, fd;
        rw = ctrl[2];
        om = ctrl[1:0];
        len = (om == 2'd0) ? nb : (om == 2'd1) ? 1 : (om == 2'd2) ? 2 : 4;
        eff = (nb < len) ? nb : len;
        if (om == 2'd0) nre = nb + 1;
        else nre = 1 + ((nb < len - 1) ? nb : len - 1);
        for (int i = 0; i < nb; i++) begin
            expm[i] = (!rw && i < eff) ? ref_rd(addr + 16'(i)) : 8'h00;
        end
        if (rw) begin
            for (int i = 0; i < eff; i++) begin
                exp_wr.push_back({addr + 16'(i), ctrl[7:3], wbuf[i]});
                ref_wr[int'(addr + 16'(i))] = wbuf[i];
            end
        end else begin
            for (int i = 0; i < nre; i++) exp_re.push_back(addr + 16'(i));
        end

        @(posedge clk);
        #1 cs = 1'b0;
        lat = 11;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("busy_rise_lat", 32'(lat), 32'd3);
        #(HALF);

        hdr = {addr, ctrl};
        acc = 1'b0;
        for (int b = 23; b >= 0; b--) begin
            spi_bit(hdr[b], r);
            acc = acc | r;
        end
        check("miso_hdr", 32'(acc), 32'd0);
        for (int i = 0; i < nb; i++) begin
            for (int b = 7; b >= 0; b--) begin
                spi_bit(wbuf[i][b], r);
                got[b] = r;
            end
            check("miso_byte", 32'(got), 32'(expm[i]));
        end
        for (int i = 0; i < xbits; i++) spi_bit(1'($urandom), r);
        #(HALF);

        @(posedge clk);
        #1 cs = 1'b1;
        lat = 11;
        fd = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0) begin
                lat = k;
                fd = frame_done;
                break;
            end
        end
        check("busy_fall_lat", 32'(lat), 32'd3);
        check("frame_done", 32'(fd), (nb > 0) ? 32'd1 : 32'd0);
        repeat (20) @(posedge clk);
        check("wr_pending", 32'(exp_wr.size()), 32'd0);
        check("re_pending", 32'(exp_re.size()), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        r;
        int          fd0;
        logic [15:0] a;
        logic [7:0]  c;

        #12;
        check("rst_ctl", {26'h0, miso, mem_we, mem_re, busy, frame_done, 1'b0}, 32'd0);
        check("rst_data", {11'h0, mem_addr, mem_bsb}, 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        #20 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
        run_frame(16'h0010, 8'b00010_1_00, 2, 0);

        wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
        run_frame(16'h0200, 8'b00001_1_10, 2, 0);
        wbuf[0] = 8'h00; wbuf[1] = 8'h00; wbuf[2] = 8'h00;
        run_frame(16'h0200, 8'b00001_0_10, 3, 0);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        run_frame(16'hFFFF, 8'b00011_1_00, 2, 0);

        wbuf[0] = 8'h96;
        run_frame(16'h1234, 8'b00100_1_00, 1, 5);
        run_frame(16'h1234, 8'b00100_0_01, 1, 0);

        fd0 = fd_cnt;
        @(posedge clk);
        #1 cs = 1'b0;
        #(HALF);
        for (int i = 0; i < 8; i++) spi_bit(1'($urandom), r);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("midrst_ctl", {26'h0, miso, mem_we, mem_re, busy, frame_done, 1'b0}, 32'd0);
        check("midrst_addr", {11'h0, mem_addr, mem_bsb}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 24; i++) spi_bit((i % 3) == 0, r);
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom), r);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 cs = 1'b1;
        repeat (20) @(posedge clk);
        check("post_rst_fd", 32'(fd_cnt - fd0), 32'd0);

        wbuf[0] = 8'h5E;
        run_frame(16'h0300, 8'b00010_1_01, 1, 0);
        run_frame(16'h0400, 8'b00010_1_00, 0, 0);

        for (int n = 0; n < 12; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 2))
                                            : 16'($urandom);
            c = 8'($urandom);
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            run_frame(a, c, $urandom_range(0, 5),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/w5500_spi_responder.md
# w5500_spi_responder

SPI target that implements the W5500 frame protocol (16-bit address, 8-bit control, N data bytes) from the device side, answering the SPI master inside the encryption engine top. It turns incoming frames into byte-wide register/buffer accesses on a local memory port and serialises read data back on MISO. It serves as a synthesizable W5500 stand-in for loopback bring-up and for closed-loop benches of the engine.

## Interface
- No parameters; SCLK is SPI mode 0 and its period must be ≥ 16 `i_clk` periods.
- `i_clk` in 1 — system clock; all logic on rising edge.
- `i_rst_n` in 1 — asynchronous, active-low reset.
- `i_spi_clk` in 1 — SCLK from master, asynchronous to `i_clk`.
- `i_spi_cs` in 1 — chip select, active-low.
- `i_spi_mosi` in 1 — serial data in, MSB first.
- `o_spi_miso` out 1 — serial data out, MSB first.
- `o_mem_addr` out 16 — byte address of current access.
- `o_mem_bsb` out 5 — block select bits from control byte.
- `o_mem_wdata` out 8 — write data.
- `o_mem_we` out 1 — one-cycle write strobe.
- `o_mem_re` out 1 — one-cycle read strobe.
- `i_mem_rdata` in 8 — read data, valid exactly one cycle after `o_mem_re`.
- `o_busy` out 1 — high from CS fall to CS rise.
- `o_frame_done` out 1 — one-cycle pulse at CS rise if ≥1 complete data byte was transferred.

## Operation
- SCLK, CS, MOSI pass through 2-FF synchronisers; edges detected on synchronised SCLK. MOSI sampled on SCLK rise; MISO shifted on SCLK fall.
- FSM: IDLE → ADDR (16 bits) → CTRL (8 bits) → DATA → SKIP. CS high in any state → IDLE next cycle.
- Control byte: [7:3] BSB, [2] RWB (1 = write), [1:0] OM: 00 variable length (until CS high), 01 = 1 byte, 10 = 2 bytes, 11 = 4 bytes.
- Write: after each complete 8th data bit, `o_mem_we` pulses with `o_mem_addr`/`o_mem_wdata`; the address then increments.
- Read: on the 8th control bit, `o_mem_re` is issued for the current address. The result is loaded into the TX shift register before the next SCLK fall, so MSB is on MISO for data bit 0. The next read (address+1) is issued after bit 7 of each byte is shifted.
- Address increments mod 2^16 (16'hFFFF → 16'h0000); BSB is unchanged.
- Fixed-length mode: after OM byte count is reached → SKIP. Further bytes are ignored: no strobes, MISO 0.
- MISO = 0 during ADDR, CTRL, SKIP, IDLE, and in write frames.
- CS rising mid-byte: the partial byte is discarded and no strobe is issued; completed bytes stay committed.

## Timing
- Reset values: `o_spi_miso`=0, `o_mem_addr`=0, `o_mem_bsb`=0, `o_mem_wdata`=0, `o_mem_we`=0, `o_mem_re`=0, `o_busy`=0, `o_frame_done`=0; FSM=IDLE, all counters 0.
- Reset asserted mid-frame: immediate return to reset values. After release, the design waits in IDLE for a CS fall; an already-low CS does not start a frame.
- Write strobe: ≤ 4 `i_clk` after the synchronised SCLK rise carrying bit 7.
- MISO update: ≤ 4 `i_clk` after the SCLK fall.
- `o_busy` rises/falls 3 `i_clk` after the CS edge (sync + detect); `o_frame_done` coincides with `o_busy` fall.
- Simultaneous CS rise and SCLK edge in the same synchronised cycle: CS wins and the edge is ignored.

## Structure
- Shared package `w5500_pkg`: FSM state enum, OM encodings, RWB bit position, BSB width, and the constants `ADDR_BITS=16` and `CTRL_BITS=8`.
- Sub-module `spi_input_sync`: 2-FF synchronisers plus SCLK rise/fall and CS fall/rise pulse generation. The instance is shared by the three inputs.

## Test plan
- Write, VDM, addr 16'h0010, ctrl 8'b00010_1_00, data AA 55 → `o_mem_we` twice: (0x0010, AA), (0x0011, 55), BSB=2; `o_frame_done` one pulse.
- Read, OM=10, addr 16'h0200, memory model returns 3C/C3 → MISO bytes 3C, C3; a 3rd clocked byte reads 00 with no `o_mem_re`.
- Address wrap: write VDM at 16'hFFFF, data 11 22 → writes at 0xFFFF then 0x0000.
- CS raised after 5 bits of the second data byte → exactly one write; `o_frame_done` pulses; the next frame parses correctly from IDLE.
- `i_rst_n` pulsed low during ADDR with CS held low → all outputs 0; no strobes until CS rises and falls again.
- Frame of ADDR+CTRL only, then CS high → no strobes, no `o_frame_done`, `o_busy` pulse 3-cycle delayed on both edges.
